// File: rtl/spi_ctrl_tx.sv
// SPI mode-0 write-only master: sends one 16-bit frame {1'b1, addr, wdata}
// MSB first per start pulse, then holds CS high for a programmable gap.
module spi_ctrl_tx #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       sclk,
  output logic       sdo,
  output logic       cs,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
  localparam logic [7:0] GAP_PRE  = 8'(CS_GAP - 2);
  localparam logic [4:0] BIT_LAST = 5'd15;

  state_t      state, state_nxt;
  logic [7:0]  div_cnt, div_cnt_nxt;
  logic [4:0]  bit_cnt, bit_cnt_nxt;
  // Holds the frame bits still to be sent; the write flag goes out straight
  // from the load, so only addr/wdata need storing.
  logic [14:0] shreg, shreg_nxt;
  logic        sclk_nxt, sdo_nxt, cs_nxt, busy_nxt, done_nxt;

  // State and every output register; outputs come straight from these flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= 8'd0;
      bit_cnt <= 5'd0;
      shreg   <= 15'd0;
      sclk    <= 1'b0;
      sdo     <= 1'b0;
      cs      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      sclk    <= sclk_nxt;
      sdo     <= sdo_nxt;
      cs      <= cs_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // Next-state logic; computes next values of all registered outputs.
  always_comb begin
    state_nxt   = state;
    div_cnt_nxt = div_cnt;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    sclk_nxt    = sclk;
    sdo_nxt     = sdo;
    cs_nxt      = cs;
    busy_nxt    = busy;
    done_nxt    = 1'b0;

    unique case (state)
      IDLE: begin
        cs_nxt   = 1'b1;
        sclk_nxt = 1'b0;
        sdo_nxt  = 1'b0;
        busy_nxt = 1'b0;
        if (start) begin
          shreg_nxt   = {addr, wdata};
          sdo_nxt     = 1'b1;
          cs_nxt      = 1'b0;
          busy_nxt    = 1'b1;
          div_cnt_nxt = 8'd0;
          bit_cnt_nxt = 5'd0;
          state_nxt   = SETUP;
        end
      end

      SETUP: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nxt = 8'd0;
          sclk_nxt    = 1'b1;
          state_nxt   = SHIFT;
        end else begin
          div_cnt_nxt = div_cnt + 8'd1;
        end
      end

      SHIFT: begin
        if (div_cnt != DIV_LAST) begin
          div_cnt_nxt = div_cnt + 8'd1;
        end else begin
          div_cnt_nxt = 8'd0;
          if (sclk) begin
            sclk_nxt = 1'b0;
            if (bit_cnt != BIT_LAST) begin
              sdo_nxt   = shreg[14];
              shreg_nxt = {shreg[13:0], 1'b0};
            end
          end else if (bit_cnt == BIT_LAST) begin
            cs_nxt    = 1'b1;
            sdo_nxt   = 1'b0;
            state_nxt = GAP;
          end else begin
            bit_cnt_nxt = bit_cnt + 5'd1;
            sclk_nxt    = 1'b1;
          end
        end
      end

      GAP: begin
        if (div_cnt == GAP_PRE) begin
          done_nxt = 1'b1;
        end
        if (div_cnt == GAP_LAST) begin
          div_cnt_nxt = 8'd0;
          busy_nxt    = 1'b0;
          state_nxt   = IDLE;
        end else begin
          div_cnt_nxt = div_cnt + 8'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_ctrl_tx.sv
// Testbench for spi_ctrl_tx: three instances (CLK_DIV 4, 3, 17), a
// cycle-level behavioural model per instance, and a loopback receiver model.
module tb_spi_ctrl_tx;

  localparam int GAP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start0, start3, start17;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       sclk0, sdo0, cs0, busy0, done0;
  logic       sclk3, sdo3, cs3, busy3, done3;
  logic       sclk17, sdo17, cs17, busy17, done17;

  spi_ctrl_tx #(.CLK_DIV(4), .CS_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .addr(addr), .wdata(wdata),
    .sclk(sclk0), .sdo(sdo0), .cs(cs0), .busy(busy0), .done(done0));

  spi_ctrl_tx #(.CLK_DIV(3), .CS_GAP(GAP)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .addr(addr), .wdata(wdata),
    .sclk(sclk3), .sdo(sdo3), .cs(cs3), .busy(busy3), .done(done3));

  spi_ctrl_tx #(.CLK_DIV(17), .CS_GAP(GAP)) dut17 (
    .clk(clk), .rst_n(rst_n), .start(start17), .addr(addr), .wdata(wdata),
    .sclk(sclk17), .sdo(sdo17), .cs(cs17), .busy(busy17), .done(done17));

  int   div_of [3] = '{4, 3, 17};
  logic st [3];
  logic [4:0] obs [3];
  assign st[0] = start0;
  assign st[1] = start3;
  assign st[2] = start17;
  assign obs[0] = {cs0, sclk0, sdo0, busy0, done0};
  assign obs[1] = {cs3, sclk3, sdo3, busy3, done3};
  assign obs[2] = {cs17, sclk17, sdo17, busy17, done17};

  int n_checks = 0;
  int n_fails  = 0;
  bit checking = 1'b0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Expected {cs, sclk, sdo, busy, done} k cycles after the accept cycle,
  // derived from the frame timing rules (k < 1 or past the gap = idle).
  function automatic logic [4:0] exp_out(input int k, input int d, input int g,
                                         input logic [15:0] f);
    int   n;
    logic s;
    if (k < 1 || k > 33 * d + g) return 5'b10000;
    if (k > 33 * d) return {4'b1001, (k == 33 * d + g)};
    s = (k > d) && (((k - d - 1) % (2 * d)) < d);
    n = (k >= 2 * d + 1) ? ((k - 2 * d - 1) / (2 * d)) + 1 : 0;
    if (n > 15) n = 15;
    return {1'b0, s, f[15 - n], 1'b1, 1'b0};
  endfunction

  // Model: tracks accepted starts per instance in absolute cycle numbers.
  longint      cyc = 0;
  bit          act [3] = '{0, 0, 0};
  longint      t0  [3] = '{0, 0, 0};
  logic [15:0] fr  [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        act[i] = 1'b0;
      end else if (st[i] && (!act[i] || (cyc - t0[i]) > 33 * div_of[i] + GAP)) begin
        act[i] = 1'b1;
        t0[i]  = cyc;
        fr[i]  = {1'b1, addr, wdata};
      end
    end
    cyc++;
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 3; i++) begin
        int k;
        k = act[i] ? int'(cyc - t0[i]) : 0;
        check_output($sformatf("outputs_div%0d_cyc%0d", div_of[i], cyc),
                     32'(obs[i]), 32'(exp_out(k, div_of[i], GAP, fr[i])));
      end
    end
  end

  // Loopback receiver: samples sdo on sclk rise, commits on cs rise if the
  // frame is a complete write to address 0..4 (stored at reg addr+1).
  logic [15:0] rx_sh = 16'h0;
  int          rx_cnt = 0;
  logic [7:0]  rx_reg [1:5] = '{default: 8'h00};
  logic        rx_psclk = 1'b0;
  logic        rx_pcs = 1'b1;

  always @(negedge clk) begin
    if (cs0 === 1'b0 && rx_pcs === 1'b1) rx_cnt = 0;
    if (cs0 === 1'b0 && sclk0 === 1'b1 && rx_psclk === 1'b0) begin
      rx_sh = {rx_sh[14:0], sdo0};
      rx_cnt++;
    end
    if (cs0 === 1'b1 && rx_pcs === 1'b0 && rx_cnt == 16 && rx_sh[15] &&
        rx_sh[14:8] < 7'd5)
      rx_reg[int'(rx_sh[14:8]) + 1] = rx_sh[7:0];
    rx_psclk = sclk0;
    rx_pcs   = cs0;
  end

  typedef struct {
    int          cs_low;
    int          rises;
    logic [15:0] bits;
    int          done_at;
    int          done_cnt;
  } meas_t;

  // Sends one frame on the CLK_DIV=4 instance and measures it; an optional
  // extra start pulse is driven at cycle extra_at after the accept cycle.
  task automatic apply_stimulus(input logic [6:0] a, input logic [7:0] d,
                                input int extra_at, input bit stop_at_done,
                                input int window, output meas_t m);
    logic prev;
    m = '{0, 0, 16'h0, 0, 0};
    prev = 1'b0;
    @(negedge clk);
    addr = a; wdata = d; start0 = 1'b1;
    for (int k = 1; k <= window; k++) begin
      @(negedge clk);
      start0 = (k == extra_at);
      if (cs0 === 1'b0) m.cs_low++;
      if (sclk0 === 1'b1 && prev === 1'b0) begin
        m.rises++;
        m.bits = {m.bits[14:0], sdo0};
      end
      prev = sclk0;
      if (done0 === 1'b1) begin
        m.done_cnt++;
        m.done_at = k;
        if (stop_at_done) break;
      end
    end
    start0 = 1'b0;
  endtask

  initial begin
    meas_t m;
    int    rises, guard, dcnt, t3, t17, hi3, hi17, bad, runs;
    logic  prev;

    rst_n = 1'b0; start0 = 1'b0; start3 = 1'b0; start17 = 1'b0;
    addr = 7'h0; wdata = 8'h0;
    repeat (3) @(negedge clk);
    check_output("reset_state_div4",  32'(obs[0]), 32'h10);
    check_output("reset_state_div3",  32'(obs[1]), 32'h10);
    check_output("reset_state_div17", 32'(obs[2]), 32'h10);
    checking = 1'b1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] basic frame addr=0x02 wdata=0xA5");
    apply_stimulus(7'h02, 8'hA5, 0, 1'b1, 200, m);
    check_output("frame_bits",   32'(m.bits), 32'h82A5);
    check_output("cs_low_count", m.cs_low, 132);
    check_output("sclk_rises",   m.rises, 16);
    check_output("done_latency", m.done_at, 140);

    $display("[TB] back-to-back loopback writes");
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(7'(i), 8'(8'h11 * (i + 1)), 0, 1'b1, 200, m);
      check_output($sformatf("b2b_latency_%0d", i), m.done_at, 140);
    end
    for (int i = 1; i <= 5; i++)
      check_output($sformatf("rx_reg%0d", i), 32'(rx_reg[i]), 32'(8'h11 * i));

    $display("[TB] out-of-range address 0x05");
    apply_stimulus(7'h05, 8'hFF, 0, 1'b1, 200, m);
    check_output("addr5_bits", 32'(m.bits), 32'h85FF);
    for (int i = 1; i <= 5; i++)
      check_output($sformatf("addr5_reg%0d", i), 32'(rx_reg[i]), 32'(8'h11 * i));

    $display("[TB] second start while busy");
    apply_stimulus(7'h03, 8'h5A, 10, 1'b0, 170, m);
    check_output("busy_start_done_cnt", m.done_cnt, 1);
    check_output("busy_start_rises",    m.rises, 16);

    $display("[TB] reset after 7th sclk rise");
    @(negedge clk);
    addr = 7'h01; wdata = 8'h7E; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    rises = 0; guard = 0; prev = 1'b0;
    while (1) begin
      if (sclk0 === 1'b1 && prev === 1'b0) rises++;
      prev = sclk0;
      if (rises == 7 || guard == 200) break;
      guard++;
      @(negedge clk);
    end
    check_output("abort_reached_7th_rise", rises, 7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_output("abort_cs_sclk_busy", 32'({cs0, sclk0, busy0}), 32'b100);
    dcnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (done0 === 1'b1) dcnt++;
    end
    check_output("abort_no_done", dcnt, 0);
    check_output("abort_reg2_kept", 32'(rx_reg[2]), 32'h22);
    apply_stimulus(7'h01, 8'h7E, 0, 1'b1, 200, m);
    check_output("retry_done_latency", m.done_at, 140);
    check_output("retry_reg2", 32'(rx_reg[2]), 32'h7E);

    $display("[TB] reset and start in the same cycle");
    @(negedge clk);
    start0 = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    start0 = 1'b0; rst_n = 1'b1;
    check_output("reset_wins_over_start", 32'({cs0, busy0}), 32'b10);
    repeat (20) @(negedge clk);
    check_output("reset_wins_still_idle", 32'(busy0), 32'b0);

    $display("[TB] CLK_DIV sweep 3 and 17");
    @(negedge clk);
    addr = 7'h2A; wdata = 8'h3C; start3 = 1'b1; start17 = 1'b1;
    @(negedge clk);
    start3 = 1'b0; start17 = 1'b0;
    t3 = 0; t17 = 0; hi3 = 0; hi17 = 0; bad = 0; runs = 0;
    for (int k = 1; k <= 700; k++) begin
      if (sclk3 === 1'b1) hi3++;
      else if (hi3 > 0) begin
        if (hi3 != 3) bad++;
        runs++;
        hi3 = 0;
      end
      if (sclk17 === 1'b1) hi17++;
      else if (hi17 > 0) begin
        if (hi17 != 17) bad++;
        runs++;
        hi17 = 0;
      end
      if (done3 === 1'b1 && t3 == 0) t3 = k;
      if (done17 === 1'b1 && t17 == 0) t17 = k;
      if (t17 != 0) break;
      @(negedge clk);
    end
    check_output("sweep_div3_latency",  t3, 107);
    check_output("sweep_div17_latency", t17, 569);
    check_output("sweep_high_runs",     runs, 32);
    check_output("sweep_bad_high_runs", bad, 0);

    repeat (5) @(negedge clk);
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/spi_ctrl_tx.md
SPI_CTRL_TX -- requirements
Module: spi_ctrl_tx

Interface
REQ-001 Parameter CLK_DIV, default 4, SHALL set the clk cycles per SCLK half-period; legal range 3..255.
REQ-002 Parameter CS_GAP, default 8, SHALL set the clk cycles CS held high after each frame before the next may start; legal range 8..255.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start  input  1  single-cycle request to send one write frame.
REQ-007 addr  input  7  target register address.
REQ-008 wdata  input  8  data byte to write.
REQ-009 sclk  output  1  SPI serial clock, idle low (mode 0).
REQ-010 sdo  output  1  serial data to the peripheral's sdi, MSB first.
REQ-011 cs  output  1  active-low chip select, idle high.
REQ-012 busy  output  1  high while a frame is in progress.
REQ-013 done  output  1  one-cycle pulse when a frame, including its CS gap, completes.

Function
REQ-014 The frame SHALL be 16 bits: {1'b1 write flag, addr[6:0], wdata[7:0]}, latched when start is accepted; later addr/wdata changes SHALL NOT affect it.
REQ-015 Start SHALL be accepted only in IDLE; start while busy=1 SHALL be ignored, not queued.
REQ-016 FSM states SHALL be IDLE, SETUP, SHIFT and GAP.
REQ-017 IDLE: cs=1, sclk=0, sdo=0, busy=0; on accepted start, the next cycle SHALL have cs=0, sdo=frame[15], busy=1, state SETUP.
REQ-018 SETUP SHALL last CLK_DIV cycles with sclk=0, then enter SHIFT.
REQ-019 SHIFT, per bit (16 bits): sclk=1 for CLK_DIV cycles, then sclk=0 for CLK_DIV cycles.
REQ-020 sdo SHALL change only in the cycle sclk falls, and SHALL be stable for the whole high phase (peripheral samples on sclk rising).
REQ-021 After the 16th bit's low phase (hold time), the FSM SHALL set cs=1, sdo=0 and enter GAP.
REQ-022 cs SHALL be low for exactly 33*CLK_DIV cycles per frame; sclk SHALL show exactly 16 rising edges per frame.
REQ-023 GAP SHALL last CS_GAP cycles with cs=1, sclk=0; in its last cycle done=1. The FSM then enters IDLE, and busy=0 from the following cycle.
REQ-024 Start-accept to done-pulse latency SHALL be 33*CLK_DIV + CS_GAP cycles; back-to-back start the cycle after done SHALL be accepted.
REQ-025 Addresses >= 5 SHALL be transmitted unmodified; filtering is the peripheral's job.
REQ-026 Half-period and gap counters SHALL be 8 bits, and the bit counter 5 bits; no counter SHALL wrap within a frame.
REQ-027 sclk, sdo and cs SHALL be driven directly from flops, with no combinational glitches.

Reset
REQ-028 While rst_n=0 at a clk edge: cs=1, sclk=0, sdo=0, busy=0, done=0, FSM=IDLE, frame and counters cleared.
REQ-029 Reset mid-frame SHALL abort the frame immediately, with cs rising at that edge; the peripheral discards the partial frame. No done pulse SHALL be generated.
REQ-030 If start and rst_n=0 occur in the same cycle, reset SHALL win and start SHALL be dropped.

Verification
REQ-031 CLK_DIV=4, CS_GAP=8; start with addr=0x02, wdata=0xA5 -> sdo bits 1000_0010_1010_0101, cs low 132 cycles, done 140 cycles after accept.
REQ-032 Loopback into the existing spi receiver: writes (0,0x11), (1,0x22), (2,0x33), (3,0x44), (4,0x55) back-to-back -> reg1..reg5 = 0x11..0x55.
REQ-033 Write addr=0x05, wdata=0xFF through the loopback -> frame sent normally, reg1..reg5 unchanged.
REQ-034 Pulse start again 10 cycles after an accepted start -> ignored: one frame only, one done pulse.
REQ-035 rst_n low for 1 cycle after the 7th sclk rise of addr=0x01, wdata=0x7E -> cs=1, sclk=0 at that edge; no done; receiver reg2 unchanged; a following write of 0x7E succeeds.
REQ-036 Sweep CLK_DIV = 3, 4, 17 -> sclk high and low phases each exactly CLK_DIV cycles; sdo never changes while sclk=1.
